// File: rtl/arriskv_pkg.sv
// Shared RV32I decode definitions: opcode constants, instruction class enum,
// and the packed record produced by the field decoder.
// No logic; types and constants only.
package arriskv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Widest raw immediate field (U and J formats carry 20 bits).
    localparam int IMM_RAW_W = 20;

    typedef enum logic [2:0] {
        INSTR_R = 3'd0,
        INSTR_I = 3'd1,
        INSTR_S = 3'd2,
        INSTR_B = 3'd3,
        INSTR_U = 3'd4,
        INSTR_J = 3'd5
    } instr_type_t;

    typedef struct packed {
        instr_type_t            instr_type;
        logic [IMM_RAW_W-1:0]   immediate;
        logic [6:0]             opcode;
        logic [4:0]             rd;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [2:0]             funct3;
        logic [6:0]             funct7;
        logic                   illegal;
    } decoded_instr_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational RV32I field extractor: classifies the word and packs the raw immediate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output tracks i_instr continuously.
// Ports: i_instr (32-bit word) -> o_dec (decoded_instr_t).
module instr_field_decode
    import arriskv_pkg::*;
(
    input  logic [31:0]     i_instr,
    output decoded_instr_t  o_dec
);

    always_comb begin
        o_dec            = '0;
        o_dec.opcode     = i_instr[6:0];
        o_dec.rd         = i_instr[11:7];
        o_dec.funct3     = i_instr[14:12];
        o_dec.rs1        = i_instr[19:15];
        o_dec.rs2        = i_instr[24:20];
        o_dec.funct7     = i_instr[31:25];
        o_dec.instr_type = INSTR_R;
        o_dec.immediate  = '0;
        o_dec.illegal    = 1'b0;

        // Immediates are left unextended and unshifted; sign_extend and the
        // execute stage apply the format-specific shift and extension.
        case (i_instr[6:0])
            OPC_OP: begin
                o_dec.instr_type = INSTR_R;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: begin
                o_dec.instr_type = INSTR_I;
                o_dec.immediate  = {8'd0, i_instr[31:20]};
            end
            OPC_STORE: begin
                o_dec.instr_type = INSTR_S;
                o_dec.immediate  = {8'd0, i_instr[31:25], i_instr[11:7]};
            end
            OPC_BRANCH: begin
                o_dec.instr_type = INSTR_B;
                o_dec.immediate  = {7'd0, i_instr[31], i_instr[7],
                                    i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                o_dec.instr_type = INSTR_U;
                o_dec.immediate  = i_instr[31:12];
            end
            OPC_JAL: begin
                o_dec.instr_type = INSTR_J;
                o_dec.immediate  = {i_instr[31], i_instr[19:12],
                                    i_instr[20], i_instr[30:21]};
            end
            default: begin
                o_dec.illegal    = 1'b1;
            end
        endcase

        // Compressed/16-bit encodings are not supported; every legal opcode
        // above already has [1:0]=11, this keeps the rule explicit.
        if (i_instr[1:0] != 2'b11) begin
            o_dec.instr_type = INSTR_R;
            o_dec.immediate  = '0;
            o_dec.illegal    = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer (main + skid) between fetch and execute.
// Latency: 1 cycle from input handshake to o_valid; full throughput under continuous i_ready.
// Backpressure: o_ready is registered and equals !skid_valid; a held main entry spills into skid.
// Ports: i_clk/i_rst_n (async active-low), i_flush, fetch side i_valid/o_ready/i_instr/i_pc,
//        execute side o_valid/i_ready/o_pc plus decoded fields o_instr_type..o_illegal.
// Optional: define ARRISKV_DECODE_PERF_EN to add o_perf_decoded and o_perf_stall counters.
module decode_stage
    import arriskv_pkg::*;
#(
    parameter int wd_regs_p = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_instr,
    input  logic [wd_regs_p-1:0]  i_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [wd_regs_p-1:0]  o_pc,
    output instr_type_t           o_instr_type,
    output logic [wd_regs_p-1:0]  o_immediate,
    output logic [6:0]            o_opcode,
    output logic [4:0]            o_rd,
    output logic [4:0]            o_rs1,
    output logic [4:0]            o_rs2,
    output logic [2:0]            o_funct3,
    output logic [6:0]            o_funct7,
    output logic                  o_illegal
`ifdef ARRISKV_DECODE_PERF_EN
    ,
    output logic [31:0]           o_perf_decoded,
    output logic [31:0]           o_perf_stall
`endif
);

    decoded_instr_t         dec;
    decoded_instr_t         main_q;
    decoded_instr_t         skid_q;
    logic [wd_regs_p-1:0]   main_pc_q;
    logic [wd_regs_p-1:0]   skid_pc_q;
    logic                   main_valid_q;
    logic                   skid_valid_q;
    logic                   ready_q;

    logic                   accept;
    logic                   drain;

    instr_field_decode u_field_decode (
        .i_instr (i_instr),
        .o_dec   (dec)
    );

    assign accept = i_valid && ready_q;
    assign drain  = main_valid_q && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_pc_q    <= '0;
            skid_pc_q    <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else if (i_flush) begin
            // Kill both entries; any handshake this cycle is dropped.
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else if (skid_valid_q) begin
            // ready_q is low here, so no accept can happen; only refill main.
            if (drain) begin
                main_q       <= skid_q;
                main_pc_q    <= skid_pc_q;
                skid_valid_q <= 1'b0;
                ready_q      <= 1'b1;
            end
        end else if (accept) begin
            if (!main_valid_q || drain) begin
                main_q       <= dec;
                main_pc_q    <= i_pc;
                main_valid_q <= 1'b1;
                ready_q      <= 1'b1;
            end else begin
                skid_q       <= dec;
                skid_pc_q    <= i_pc;
                skid_valid_q <= 1'b1;
                ready_q      <= 1'b0;
            end
        end else begin
            if (drain) begin
                main_valid_q <= 1'b0;
            end
            ready_q <= 1'b1;
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = main_valid_q;
    assign o_pc         = main_pc_q;
    assign o_instr_type = main_q.instr_type;
    assign o_immediate  = {{(wd_regs_p-IMM_RAW_W){1'b0}}, main_q.immediate};
    assign o_opcode     = main_q.opcode;
    assign o_rd         = main_q.rd;
    assign o_rs1        = main_q.rs1;
    assign o_rs2        = main_q.rs2;
    assign o_funct3     = main_q.funct3;
    assign o_funct7     = main_q.funct7;
    assign o_illegal    = main_q.illegal;

`ifdef ARRISKV_DECODE_PERF_EN
    // Counters are observability only: flush leaves them alone, they wrap freely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_perf_decoded <= '0;
            o_perf_stall   <= '0;
        end else begin
            if (main_valid_q && i_ready) begin
                o_perf_decoded <= o_perf_decoded + 32'd1;
            end
            if (main_valid_q && !i_ready) begin
                o_perf_stall <= o_perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import arriskv_pkg::*;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_flush;
    logic         i_valid;
    logic         o_ready;
    logic [31:0]  i_instr;
    logic [31:0]  i_pc;
    logic         o_valid;
    logic         i_ready;
    logic [31:0]  o_pc;
    instr_type_t  o_instr_type;
    logic [31:0]  o_immediate;
    logic [6:0]   o_opcode;
    logic [4:0]   o_rd;
    logic [4:0]   o_rs1;
    logic [4:0]   o_rs2;
    logic [2:0]   o_funct3;
    logic [6:0]   o_funct7;
    logic         o_illegal;
`ifdef ARRISKV_DECODE_PERF_EN
    logic [31:0]  o_perf_decoded;
    logic [31:0]  o_perf_stall;
    int           exp_decoded = 0;
    int           exp_stall   = 0;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    decode_stage #(.wd_regs_p(32)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_instr      (i_instr),
        .i_pc         (i_pc),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_pc         (o_pc),
        .o_instr_type (o_instr_type),
        .o_immediate  (o_immediate),
        .o_opcode     (o_opcode),
        .o_rd         (o_rd),
        .o_rs1        (o_rs1),
        .o_rs2        (o_rs2),
        .o_funct3     (o_funct3),
        .o_funct7     (o_funct7),
        .o_illegal    (o_illegal)
`ifdef ARRISKV_DECODE_PERF_EN
        ,
        .o_perf_decoded (o_perf_decoded),
        .o_perf_stall   (o_perf_stall)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
`ifdef ARRISKV_DECODE_PERF_EN
        if (i_rst_n && o_valid && i_ready)  exp_decoded++;
        if (i_rst_n && o_valid && !i_ready) exp_stall++;
`endif
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        i_valid = v;
        i_instr = ins;
        i_pc    = pc;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // Reset state
        #2;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_pc",    o_pc,         32'd0);
        chk("rst_imm",   o_immediate,  32'd0);
        #10 i_rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(o_ready), 32'd1);
        chk("post_rst_valid", 32'(o_valid), 32'd0);

        // ADDI x1,x2,-1
        i_ready = 1'b1;
        drive(1'b1, 32'hFFF10093, 32'h100);
        step();
        chk("addi_valid", 32'(o_valid),      32'd1);
        chk("addi_type",  32'(o_instr_type), 32'(INSTR_I));
        chk("addi_imm",   o_immediate,       32'h00000FFF);
        chk("addi_rd",    32'(o_rd),         32'd1);
        chk("addi_rs1",   32'(o_rs1),        32'd2);
        chk("addi_ill",   32'(o_illegal),    32'd0);
        chk("addi_pc",    o_pc,              32'h100);
        chk("addi_opc",   32'(o_opcode),     32'h13);

        // BEQ x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 32'h104);
        step();
        chk("beq_type", 32'(o_instr_type), 32'(INSTR_B));
        chk("beq_imm",  o_immediate,       32'h00001FFC);
        chk("beq_pc",   o_pc,              32'h104);

        // JAL x0,-8
        drive(1'b1, 32'hFF9FF06F, 32'h108);
        step();
        chk("jal_type", 32'(o_instr_type), 32'(INSTR_J));
        chk("jal_imm",  o_immediate,       32'h000FFFFC);
        chk("jal_rd",   32'(o_rd),         32'd0);

        // SW x5,8(x2)
        drive(1'b1, 32'h00512423, 32'h10C);
        step();
        chk("sw_type", 32'(o_instr_type), 32'(INSTR_S));
        chk("sw_imm",  o_immediate,       32'h00000008);
        chk("sw_rs2",  32'(o_rs2),        32'd5);
        chk("sw_f3",   32'(o_funct3),     32'd2);

        // LUI x5,0x12345
        drive(1'b1, 32'h123452B7, 32'h110);
        step();
        chk("lui_type", 32'(o_instr_type), 32'(INSTR_U));
        chk("lui_imm",  o_immediate,       32'h00012345);
        chk("lui_rd",   32'(o_rd),         32'd5);

        // SUB x3,x1,x2
        drive(1'b1, 32'h402081B3, 32'h114);
        step();
        chk("sub_type", 32'(o_instr_type), 32'(INSTR_R));
        chk("sub_f7",   32'(o_funct7),     32'h20);
        chk("sub_imm",  o_immediate,       32'd0);
        chk("sub_ill",  32'(o_illegal),    32'd0);

        // Drain
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("drain_valid", 32'(o_valid), 32'd0);

        // Backpressure: A, B accepted, C refused while full
        i_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h200);
        step();
        chk("bp_a_valid", 32'(o_valid), 32'd1);
        chk("bp_a_ready", 32'(o_ready), 32'd1);
        drive(1'b1, 32'h00200113, 32'h204);
        step();
        chk("bp_b_ready", 32'(o_ready), 32'd0);
        chk("bp_b_pc",    o_pc,         32'h200);
        drive(1'b1, 32'h00300193, 32'h208);
        step();
        chk("bp_full_pc",    o_pc,         32'h200);
        chk("bp_full_ready", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        step();
        chk("bp_rel_pc",    o_pc,         32'h204);
        chk("bp_rel_imm",   o_immediate,  32'd2);
        chk("bp_rel_ready", 32'(o_ready), 32'd1);
        step();
        chk("bp_c_pc",  o_pc,        32'h208);
        chk("bp_c_imm", o_immediate, 32'd3);
        drive(1'b1, 32'h00400213, 32'h20C);
        step();
        chk("b2b_d_pc", o_pc, 32'h20C);
        drive(1'b1, 32'h00500293, 32'h210);
        step();
        chk("b2b_e_pc",    o_pc,         32'h210);
        chk("b2b_e_valid", 32'(o_valid), 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("b2b_end_valid", 32'(o_valid), 32'd0);

        // Flush with both entries full and fetch offering
        i_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h300);
        step();
        drive(1'b1, 32'h00200113, 32'h304);
        step();
        chk("fl_full_ready", 32'(o_ready), 32'd0);
        drive(1'b1, 32'h00300193, 32'h308);
        i_flush = 1'b1;
        step();
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_ready", 32'(o_ready), 32'd1);
        // Flush while a handshake is accepted: that instruction is discarded
        drive(1'b1, 32'h00400213, 32'h30C);
        step();
        chk("fl_hs_valid", 32'(o_valid), 32'd0);
        i_flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        i_ready = 1'b1;
        step();
        chk("fl_after_valid", 32'(o_valid), 32'd0);

        // Illegal encodings
        drive(1'b1, 32'h0000007F, 32'h400);
        step();
        chk("ill7f_ill",  32'(o_illegal),    32'd1);
        chk("ill7f_imm",  o_immediate,       32'd0);
        chk("ill7f_type", 32'(o_instr_type), 32'(INSTR_R));
        drive(1'b1, 32'hFFF00010, 32'h404);
        step();
        chk("ill10_ill", 32'(o_illegal), 32'd1);
        chk("ill10_imm", o_immediate,    32'd0);
        drive(1'b1, 32'h00000013, 32'h408);
        step();
        chk("nop_ill", 32'(o_illegal), 32'd0);

        // Fill both entries again, then reset asynchronously mid-stream
        i_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h500);
        step();
        drive(1'b1, 32'h00200113, 32'h504);
        step();
        chk("pre_rst_ready", 32'(o_ready), 32'd0);
`ifdef ARRISKV_DECODE_PERF_EN
        chk("perf_decoded", o_perf_decoded, 32'(exp_decoded));
        chk("perf_stall",   o_perf_stall,   32'(exp_stall));
`endif
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid),      32'd0);
        chk("mid_rst_ready", 32'(o_ready),      32'd0);
        chk("mid_rst_pc",    o_pc,              32'd0);
        chk("mid_rst_imm",   o_immediate,       32'd0);
        chk("mid_rst_rd",    32'(o_rd),         32'd0);
        chk("mid_rst_type",  32'(o_instr_type), 32'd0);
`ifdef ARRISKV_DECODE_PERF_EN
        chk("mid_rst_perf", o_perf_decoded, 32'd0);
`endif
        drive(1'b0, 32'h0, 32'h0);
        #10 i_rst_n = 1'b1;
        step();
        chk("rel_ready", 32'(o_ready), 32'd1);
        chk("rel_valid", 32'(o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I decode stage between instruction fetch and execute.
- Accepts fetched instruction words over a valid/ready handshake.
- Classifies each word into instr_type_t.
- Extracts register indices and function fields.
- Reassembles the raw, unextended immediate in the bit layout that sign_extend consumes.
- Contains a 2-entry skid buffer, giving full throughput with registered o_ready.

Parameters:
wd_regs_p, 32, datapath/register width; also width of PC and immediate outputs.

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  asynchronous active-low reset.
i_flush  in  1  synchronous kill of all held instructions.
i_valid  in  1  fetch has an instruction.
o_ready  out  1  stage can accept an instruction.
i_instr  in  32  instruction word.
i_pc  in  wd_regs_p  PC of i_instr.
o_valid  out  1  decoded instruction available.
i_ready  in  1  execute accepts the decoded instruction.
o_pc  out  wd_regs_p  PC of the decoded instruction.
o_instr_type  out  instr_type_t  R/I/S/B/U/J class.
o_immediate  out  wd_regs_p  raw immediate, zero above its field width.
o_opcode  out  7  instr[6:0].
o_rd  out  5  instr[11:7].
o_rs1  out  5  instr[19:15].
o_rs2  out  5  instr[24:20].
o_funct3  out  3  instr[14:12].
o_funct7  out  7  instr[31:25].
o_illegal  out  1  unsupported opcode, or instr[1:0] != 2'b11.

Behaviour:
- Reset (i_rst_n low, asynchronous): all outputs 0, both buffer entries invalid. After release, o_ready=1.
- Transfers: input transfer when i_valid && o_ready; output transfer when o_valid && i_ready.
- Latency: 1 cycle. An instruction accepted at edge N appears on o_* after edge N.
- Buffer: output register (main) plus skid register.
  - o_ready = !skid_valid, registered.
  - Accept while main is empty or draining: decode into main.
  - Accept while main is held (i_ready=0): decode into skid.
  - Main drains with skid valid: skid moves to main.
  - Order is strictly FIFO. Never drop or duplicate.
- Simultaneous accept and drain with skid empty: main reloads; skid stays empty.
- Full (both entries valid): o_ready=0, and i_instr is ignored.
- Flush: at the next edge main_valid=0 and skid_valid=0.
  - An input handshake in the flush cycle is discarded.
  - o_valid=0 the cycle after flush. Flush has priority over all other events.
- Decode is combinational on i_instr, registered on accept. Data outputs hold while o_valid && !i_ready.
- Opcode classification:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Anything else → R with o_illegal=1 and immediate 0.
- Immediate layout (upper bits 0):
  - I: instr[31:20] in [11:0].
  - S: {instr[31:25], instr[11:7]} in [11:0].
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} in [12:0].
  - U: instr[31:12] in [19:0]. Shift by 12 is done downstream.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21]} in [19:0], i.e. imm[20:1]. Shift by 1 is done downstream.
  - R: 0.

Optional Feature:
ARRISKV_DECODE_PERF_EN adds two outputs:
- o_perf_decoded[31:0]: increments on every output transfer.
- o_perf_stall[31:0]: increments every cycle with o_valid && !i_ready.

Both counters reset to 0, wrap at 2^32, and are not cleared by flush. Without the macro, these ports and counters do not exist.

Decomposition:
- arriskv_pkg: add opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL). Add R to instr_type_t if absent. Add a packed struct decoded_instr_t holding the output fields.
- One sub-module, instr_field_decode: purely combinational, i_instr → decoded_instr_t. It is instantiated once; its output feeds both buffer entries.

Test Plan:
- Reset: hold i_rst_n=0 mid-stream with both entries full → o_valid=0, all outputs 0; after release o_ready=1.
- ADDI x1,x2,-1 (0xFFF10093), i_ready=1 → next cycle o_instr_type=I, o_immediate=0x00000FFF, o_rd=1, o_rs1=2, o_illegal=0.
- BEQ x0,x0,-4 (0xFE000EE3) → type B, o_immediate=0x00001FFC. JAL x0,-8 (0xFF9FF06F) → type J, o_immediate=0x000FFFFC.
- Backpressure: stream 3 instructions with i_i_ready=0 held 3 cycles → o_ready falls after the 2nd accept. On release, outputs appear in order with no loss or duplication, and a back-to-back stream then sustains 1 instruction per cycle.
- Flush with both entries full plus i_valid=1 → next cycle o_valid=0, o_ready=1; the flushed-cycle instruction never appears.
- i_instr=0x0000007F, and i_instr=0x00000013 with bits[1:0] forced to 00 → o_illegal=1, o_immediate=0. With ARRISKV_DECODE_PERF_EN, o_perf_decoded and o_perf_stall match bench counts.
